// File: rtl/dm_responder.sv
// Data-memory responder: single-outstanding word-addressed load/store target with
// programmable wait states, byte-enabled stores and illegal-access flagging.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state;
  logic [31:0]             mem [DEPTH];
  logic [3:0]              wait_cnt;
  logic                    lat_we;
  logic                    lat_err;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [3:0]              lat_be;
  logic [31:0]             lat_wdata;

  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    addr_oob;
  logic                    be_ok;
  logic                    req_err;
  logic                    unused_addr_lsb;

  assign req_idx         = req_addr[DEPTH_LOG2+1:2];
  assign addr_oob        = |req_addr[31:DEPTH_LOG2+2];
  assign unused_addr_lsb = ^req_addr[1:0];

  // Only naturally aligned byte, halfword and word lanes are legal store shapes.
  always_comb begin
    be_ok = 1'b0;
    case (req_byteen)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase
  end

  assign req_err = addr_oob | (req_we & ~be_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_err   <= req_err;
            lat_idx   <= req_idx;
            lat_be    <= req_byteen;
            lat_wdata <= req_wdata;
            wait_cnt  <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            // Zero wait states: read straight from the incoming index, skipping the latch.
            if (WAIT_CYCLES == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= req_err;
              resp_rdata <= (req_we || req_err) ? '0 : mem[req_idx];
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= lat_err;
            resp_rdata <= (lat_we || lat_err) ? '0 : mem[lat_idx];
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          if (lat_we && !lat_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (lat_be[b]) begin
                mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
              end
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: vector table on a zero-wait instance, hand sequences
// for wait-state timing, held requests and mid-operation reset on a 3-wait instance.
module tb_dm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3;
  logic        d0_req_valid, d0_req_ready, d0_req_we, d0_resp_valid, d0_resp_err;
  logic [31:0] d0_req_addr, d0_req_wdata, d0_resp_rdata;
  logic [3:0]  d0_req_byteen;
  logic        d3_req_valid, d3_req_ready, d3_req_we, d3_resp_valid, d3_resp_err;
  logic [31:0] d3_req_addr, d3_req_wdata, d3_resp_rdata;
  logic [3:0]  d3_req_byteen;

  dm_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0),
    .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
    .req_addr(d0_req_addr), .req_byteen(d0_req_byteen), .req_wdata(d0_req_wdata),
    .resp_valid(d0_resp_valid), .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err)
  );

  dm_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_we(d3_req_we),
    .req_addr(d3_req_addr), .req_byteen(d3_req_byteen), .req_wdata(d3_req_wdata),
    .resp_valid(d3_resp_valid), .resp_rdata(d3_resp_rdata), .resp_err(d3_resp_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One zero-wait transaction; entered and left at #1 after a rising edge with dut0 idle.
  task automatic txn0(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, "_ready_pre"}, 32'(d0_req_ready), 32'd1);
    d0_req_valid = 1'b1; d0_req_we = v.we; d0_req_addr = v.addr;
    d0_req_byteen = v.be; d0_req_wdata = v.wdata;
    step();
    d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_addr = '0; d0_req_byteen = '0; d0_req_wdata = '0;
    check({tag, "_resp_valid"}, 32'(d0_resp_valid), 32'd1);
    check({tag, "_ready_busy"}, 32'(d0_req_ready), 32'd0);
    check({tag, "_rdata"}, d0_resp_rdata, v.exp_rdata);
    check({tag, "_err"}, 32'(d0_resp_err), 32'(v.exp_err));
    step();
    check({tag, "_resp_drop"}, 32'(d0_resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(d0_req_ready), 32'd1);
    check({tag, "_rdata_idle"}, d0_resp_rdata, 32'd0);
  endtask

  // Three-wait transaction with a bounded wait; latency counted in cycles after accept.
  task automatic txn3(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    check({tag, "_ready_pre"}, 32'(d3_req_ready), 32'd1);
    d3_req_valid = 1'b1; d3_req_we = we; d3_req_addr = addr; d3_req_byteen = be; d3_req_wdata = wdata;
    step();
    d3_req_valid = 1'b0;
    lat = 1;
    while (!d3_resp_valid && lat < 12) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_rdata"}, d3_resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(d3_resp_err), 32'(exp_err));
    step();
    check({tag, "_ready_back"}, 32'(d3_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst0 = 1'b1; rst3 = 1'b1;
    d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_addr = '0; d0_req_byteen = '0; d0_req_wdata = '0;
    d3_req_valid = 1'b0; d3_req_we = 1'b0; d3_req_addr = '0; d3_req_byteen = '0; d3_req_wdata = '0;

    //     we    addr          be       wdata         exp_rdata     err
    add(1'b0, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000_0000, 1'b0);
    add(1'b1, 32'h0000_0100, 4'b1111, 32'h12345678, 32'h0000_0000, 1'b0);
    add(1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h12345678, 1'b0);
    add(1'b1, 32'h0000_0100, 4'b0010, 32'hAABBCCDD, 32'h0000_0000, 1'b0);
    add(1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h1234CC78, 1'b0);
    add(1'b1, 32'h0000_0100, 4'b1100, 32'hEEFF0000, 32'h0000_0000, 1'b0);
    add(1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hEEFFCC78, 1'b0);
    add(1'b1, 32'h0001_0000, 4'b1111, 32'h55555555, 32'h0000_0000, 1'b1);
    add(1'b1, 32'h0000_0100, 4'b0110, 32'hFFFFFFFF, 32'h0000_0000, 1'b1);
    add(1'b1, 32'h0000_0100, 4'b0000, 32'hFFFFFFFF, 32'h0000_0000, 1'b1);
    add(1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hEEFFCC78, 1'b0);
    add(1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'h0000_0000, 1'b1);
    add(1'b1, 32'h0000_3FFC, 4'b1111, 32'hCAFEF00D, 32'h0000_0000, 1'b0);
    add(1'b0, 32'h0000_3FFF, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0);
    add(1'b1, 32'h0000_0104, 4'b0001, 32'h000000AB, 32'h0000_0000, 1'b0);
    add(1'b1, 32'h0000_0105, 4'b1000, 32'h11000000, 32'h0000_0000, 1'b0);
    add(1'b0, 32'h0000_0107, 4'b0000, 32'h0,        32'h110000AB, 1'b0);
    add(1'b1, 32'h0000_0104, 4'b0011, 32'h0000BEEF, 32'h0000_0000, 1'b0);
    add(1'b0, 32'h0000_0104, 4'b1111, 32'h0,        32'h1100BEEF, 1'b0);

    step();
    rst0 = 1'b0; rst3 = 1'b0;
    check("rst_ready0", 32'(d0_req_ready), 32'd1);
    check("rst_valid0", 32'(d0_resp_valid), 32'd0);
    check("rst_rdata0", d0_resp_rdata, 32'd0);
    check("rst_err0", 32'(d0_resp_err), 32'd0);
    check("rst_ready3", 32'(d3_req_ready), 32'd1);
    check("rst_valid3", 32'(d3_resp_valid), 32'd0);

    foreach (vecs[i]) txn0(i, vecs[i]);

    // Reset and request in the same cycle: reset wins, nothing is accepted.
    rst0 = 1'b1; d0_req_valid = 1'b1; d0_req_we = 1'b1;
    d0_req_addr = 32'h0000_0200; d0_req_byteen = 4'b1111; d0_req_wdata = 32'h13572468;
    step();
    rst0 = 1'b0; d0_req_valid = 1'b0;
    check("rstreq_ready", 32'(d0_req_ready), 32'd1);
    check("rstreq_valid", 32'(d0_resp_valid), 32'd0);
    step();
    check("rstreq_valid2", 32'(d0_resp_valid), 32'd0);
    txn0(100, '{1'b0, 32'h0000_0100, 4'b0000, 32'h0, 32'h0, 1'b0});
    txn0(101, '{1'b0, 32'h0000_0200, 4'b0000, 32'h0, 32'h0, 1'b0});

    // Wait-state timing with a second request held through the busy window.
    d3_req_valid = 1'b1; d3_req_we = 1'b1; d3_req_addr = 32'h8;
    d3_req_byteen = 4'b1111; d3_req_wdata = 32'hDEADBEEF;
    step();
    d3_req_we = 1'b0; d3_req_byteen = 4'b0000; d3_req_wdata = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("hold_ready_n%0d", k), 32'(d3_req_ready), 32'd0);
      check($sformatf("hold_valid_n%0d", k), 32'(d3_resp_valid), 32'(k == 4));
      if (k == 4) check("hold_store_err", 32'(d3_resp_err), 32'd0);
      step();
    end
    check("hold_ready_n5", 32'(d3_req_ready), 32'd1);
    check("hold_valid_n5", 32'(d3_resp_valid), 32'd0);
    step();
    d3_req_valid = 1'b0;
    check("hold_accept_n6", 32'(d3_req_ready), 32'd0);
    for (int k = 6; k <= 9; k++) begin
      check($sformatf("hold_valid2_n%0d", k), 32'(d3_resp_valid), 32'(k == 9));
      if (k == 9) check("hold_load_rdata", d3_resp_rdata, 32'hDEADBEEF);
      step();
    end
    check("hold_ready_end", 32'(d3_req_ready), 32'd1);

    txn3("w3_err", 1'b1, 32'h0001_0000, 4'b1111, 32'h1, 32'h0, 1'b1);
    txn3("w3_load", 1'b0, 32'h0000_0008, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT: pending store dropped, memory cleared, no response.
    d3_req_valid = 1'b1; d3_req_we = 1'b1; d3_req_addr = 32'h8;
    d3_req_byteen = 4'b1111; d3_req_wdata = 32'h01020304;
    step();
    d3_req_valid = 1'b0;
    step();
    rst3 = 1'b1;
    step();
    rst3 = 1'b0;
    check("midrst_ready", 32'(d3_req_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (d3_resp_valid) seen++;
      step();
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    txn3("midrst_load", 1'b0, 32'h0000_0008, 4'b0000, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
